// File: rtl/crossing_pkg.sv
// crossing_pkg: shared constants and the FSM state encoding for the
// level-crossing sequencer.
//   RATIO_SHIFT  log2 of the distance ratio dis_s2/dis_s1_s2 (16 -> 4)
//   LEAD_MS      safety lead subtracted from the predicted arrival (ms)
//   T_W / P_W    widths of the transit time and of the prediction/countdown
//   CLOSE_MAX_MS closed-hold timeout, used only with CLOSE_TIMEOUT_EN
package crossing_pkg;
  localparam int RATIO_SHIFT  = 4;
  localparam int LEAD_MS      = 30000;
  localparam int T_W          = 15;
  localparam int P_W          = T_W + RATIO_SHIFT;
  localparam int CLOSE_MAX_MS = 60000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_PREDICT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CLOSED  = 3'd4
  } state_t;
endpackage

// File: rtl/arrival_calc.sv
// arrival_calc: combinational arrival predictor.
//   meas_ms  in : measured S1->S2 transit time (ms)
//   pred_ms  out: (meas_ms << RATIO_SHIFT) - LEAD_MS, clamped at 0
// P_W = T_W + RATIO_SHIFT, so the shifted product never overflows.
module arrival_calc #(
  parameter int T_W         = crossing_pkg::T_W,
  parameter int P_W         = crossing_pkg::P_W,
  parameter int RATIO_SHIFT = crossing_pkg::RATIO_SHIFT,
  parameter int LEAD_MS     = crossing_pkg::LEAD_MS
) (
  input  logic [T_W-1:0] meas_ms,
  output logic [P_W-1:0] pred_ms
);
  localparam logic [P_W-1:0] LEAD = P_W'(LEAD_MS);

  logic [P_W-1:0] prod;

  assign prod    = P_W'(meas_ms) << RATIO_SHIFT;
  // A product at or below the lead means the gate must close right away.
  assign pred_ms = (prod > LEAD) ? (prod - LEAD) : '0;
endmodule

// File: rtl/crossing_sequencer.sv
// crossing_sequencer: sequences one train passage at the level crossing.
// Measures S1->S2 transit, predicts the arrival delay, counts it down in
// ms ticks, then holds the gate closed until the exit sensor S3.
//   clk, rst_n   clock, async active-low reset
//   tick_ms      1 ms enable strobe
//   s1, s2, s3   entry / second / exit sensor pulses (debounced, sync)
//   gate_close   registered gate command (1 = closed)
//   busy         state != IDLE (registered)
//   meas_ms      latched transit time
//   pred_ms      latched prediction
//   err          one-cycle error pulse
//   state_o      current FSM state (debug)
// Optional macro CLOSE_TIMEOUT_EN: abort CLOSED with err after
// CLOSE_MAX_MS ticks without S3.
module crossing_sequencer #(
  parameter int RATIO_SHIFT  = crossing_pkg::RATIO_SHIFT,
  parameter int LEAD_MS      = crossing_pkg::LEAD_MS,
  parameter int T_W          = crossing_pkg::T_W,
  parameter int P_W          = crossing_pkg::P_W,
  parameter int CLOSE_MAX_MS = crossing_pkg::CLOSE_MAX_MS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick_ms,
  input  logic           s1,
  input  logic           s2,
  input  logic           s3,
  output logic           gate_close,
  output logic           busy,
  output logic [T_W-1:0] meas_ms,
  output logic [P_W-1:0] pred_ms,
  output logic           err,
  output logic [2:0]     state_o
);
  import crossing_pkg::*;

  state_t         state, state_n;
  logic [T_W-1:0] t, t_n, meas_n;
  logic [P_W-1:0] cnt, cnt_n, pred_n, calc_pred;
  logic           err_n;

  arrival_calc #(
    .T_W(T_W), .P_W(P_W), .RATIO_SHIFT(RATIO_SHIFT), .LEAD_MS(LEAD_MS)
  ) u_calc (
    .meas_ms(meas_ms),
    .pred_ms(calc_pred)
  );

`ifdef CLOSE_TIMEOUT_EN
  localparam int H_W = $clog2(CLOSE_MAX_MS + 1);
  logic [H_W-1:0] hold, hold_n;
`endif

  always_comb begin
    state_n = state;
    t_n     = t;
    cnt_n   = cnt;
    meas_n  = meas_ms;
    pred_n  = pred_ms;
    err_n   = 1'b0;
`ifdef CLOSE_TIMEOUT_EN
    hold_n  = hold;
`endif
    unique case (state)
      ST_IDLE: begin
        if (s1) begin
          state_n = ST_MEASURE;
          t_n     = '0;
        end
      end
      ST_MEASURE: begin
        // s2 wins over a same-cycle tick: the tick is simply dropped.
        if (s2) begin
          meas_n  = t;
          state_n = ST_PREDICT;
        end else if (s3) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (tick_ms) begin
          if (t == '1) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            t_n = t + 1'b1;
          end
        end
      end
      ST_PREDICT: begin
        pred_n  = calc_pred;
        cnt_n   = calc_pred;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (s3) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          state_n = ST_CLOSED;
`ifdef CLOSE_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else if (tick_ms) begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_CLOSED: begin
        if (s3) begin
          state_n = ST_IDLE;
        end
`ifdef CLOSE_TIMEOUT_EN
        else if (tick_ms) begin
          // This tick would bring the hold count to CLOSE_MAX_MS.
          if (hold == H_W'(CLOSE_MAX_MS - 1)) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      t          <= '0;
      cnt        <= '0;
      meas_ms    <= '0;
      pred_ms    <= '0;
      err        <= 1'b0;
      gate_close <= 1'b0;
      busy       <= 1'b0;
`ifdef CLOSE_TIMEOUT_EN
      hold       <= '0;
`endif
    end else begin
      state      <= state_n;
      t          <= t_n;
      cnt        <= cnt_n;
      meas_ms    <= meas_n;
      pred_ms    <= pred_n;
      err        <= err_n;
      // Registered from next state so they line up with state_o.
      gate_close <= (state_n == ST_CLOSED);
      busy       <= (state_n != ST_IDLE);
`ifdef CLOSE_TIMEOUT_EN
      hold       <= hold_n;
`endif
    end
  end

  assign state_o = state;
endmodule
